ps2_key_event_sequencer: RTL

//  Sits after the PS/2 keyboard wrapper. Consumes the raw scan-code byte stream (ScanData/Valid)
//  and sequences set-2 prefix bytes (E0, F0, E1) into single key events {ext, break, code}.

---
 rtl/ps2_key_event_sequencer_if.sv | 26 ++
 rtl/ps2_key_event_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_sequencer_if.sv
// Handshake bundle between the PS/2 keyboard wrapper, the key event sequencer and its consumer.
// The sequencer takes the slave modport and the surrounding logic drives the master side.
interface ps2_key_event_sequencer_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [7:0]                  scanData;
    logic                        scanValid;
    logic [7:0]                  eventCode;
    logic                        eventExt;
    logic                        eventBreak;
    logic                        eventValid;
    logic                        eventReady;
    logic [$clog2(FIFO_DEPTH):0] fifoCount;
    logic                        overflow;
    logic                        ovfClear;

    modport master (
        output scanData, scanValid, eventReady, ovfClear,
        input  eventCode, eventExt, eventBreak, eventValid, fifoCount, overflow
    );

    modport slave (
        input  scanData, scanValid, eventReady, ovfClear,
        output eventCode, eventExt, eventBreak, eventValid, fifoCount, overflow
    );
endinterface

// File: rtl/ps2_key_event_sequencer.sv
// Folds PS/2 set-2 prefix bytes into {ext, break, code} key events and queues them in a FWFT FIFO.
// Define TYPEMATIC_FILTER_EN to suppress repeated make events for keys that are already held.
module ps2_key_event_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst,
    ps2_key_event_sequencer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_PAUSE} state_t;

    state_t          r_state, w_stateNext;
    logic [2:0]      r_pauseCnt, w_pauseCntNext;
    logic [TW-1:0]   r_toCnt;
    logic            r_scanValidQ;
    logic            w_strobe, w_timeout, w_isPrefix, w_isCtrl;
    logic            r_pushValid, r_pushExt, r_pushBrk;
    logic [7:0]      r_pushCode;
    logic            w_pushValid, w_pushExt, w_pushBrk;
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wrPtr, r_rdPtr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            w_full, w_pop, w_suppress, w_push, w_write, w_drop;
    logic [9:0]      w_head;

    assign w_strobe   = bus.scanValid & ~r_scanValidQ;
    assign w_timeout  = (r_state != S_IDLE) && (r_toCnt == TO_LAST);
    assign w_isPrefix = (bus.scanData == 8'hE0) || (bus.scanData == 8'hF0) || (bus.scanData == 8'hE1);
    assign w_isCtrl   = (bus.scanData == 8'hAA) || (bus.scanData == 8'hFA) || (bus.scanData == 8'hEE) ||
                        (bus.scanData == 8'hFE) || (bus.scanData == 8'h00) || (bus.scanData == 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pauseCnt   <= '0;
            r_toCnt      <= '0;
            r_scanValidQ <= 1'b0;
            r_pushValid  <= 1'b0;
            r_pushExt    <= 1'b0;
            r_pushBrk    <= 1'b0;
            r_pushCode   <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_pauseCnt   <= w_pauseCntNext;
            r_scanValidQ <= bus.scanValid;
            r_pushValid  <= w_pushValid;
            r_pushExt    <= w_pushExt;
            r_pushBrk    <= w_pushBrk;
            r_pushCode   <= bus.scanData;
            if (w_strobe || (r_state == S_IDLE) || w_timeout) r_toCnt <= '0;
            else                                             r_toCnt <= r_toCnt + TW'(1);
        end
    end

    // A strobe always takes precedence over the inter-byte timeout.
    always_comb begin
        w_stateNext    = r_state;
        w_pauseCntNext = r_pauseCnt;
        w_pushValid    = 1'b0;
        w_pushExt      = 1'b0;
        w_pushBrk      = 1'b0;
        if (w_strobe) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.scanData == 8'hE0)      w_stateNext = S_EXT;
                    else if (bus.scanData == 8'hF0) w_stateNext = S_BRK;
                    else if (bus.scanData == 8'hE1) begin
                        w_stateNext    = S_PAUSE;
                        w_pauseCntNext = 3'd7;
                    end else if (!w_isCtrl)         w_pushValid = 1'b1;
                end
                S_EXT: begin
                    if (bus.scanData == 8'hF0) w_stateNext = S_EXTBRK;
                    else begin
                        w_stateNext = S_IDLE;
                        w_pushValid = !w_isPrefix && !w_isCtrl;
                        w_pushExt   = 1'b1;
                    end
                end
                S_BRK, S_EXTBRK: begin
                    w_stateNext = S_IDLE;
                    w_pushValid = !w_isPrefix && !w_isCtrl;
                    w_pushExt   = (r_state == S_EXTBRK);
                    w_pushBrk   = 1'b1;
                end
                S_PAUSE: begin
                    w_pauseCntNext = r_pauseCnt - 3'd1;
                    if (r_pauseCnt == 3'd1) w_stateNext = S_IDLE;
                end
                default: w_stateNext = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_stateNext = S_IDLE;
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    logic [511:0] r_held;

    assign w_suppress = ~r_pushBrk & r_held[{r_pushExt, r_pushCode}];

    // Held state only follows events that actually reach the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_held <= '0;
        else if (w_write) r_held[{r_pushExt, r_pushCode}] <= ~r_pushBrk;
    end
`else
    assign w_suppress = 1'b0;
`endif

    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = bus.eventValid & bus.eventReady;
    assign w_push  = r_pushValid & ~w_suppress;
    assign w_write = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wrPtr] <= {r_pushExt, r_pushBrk, r_pushCode};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)   r_rdPtr <= r_rdPtr + AW'(1);
            r_count <= r_count + CW'(w_write) - CW'(w_pop);
            if (w_drop)            r_overflow <= 1'b1;
            else if (bus.ovfClear) r_overflow <= 1'b0;
        end
    end

    assign w_head         = r_mem[r_rdPtr];
    assign bus.eventValid = (r_count != '0);
    assign bus.eventCode  = bus.eventValid ? w_head[7:0] : 8'h00;
    assign bus.eventBreak = bus.eventValid & w_head[8];
    assign bus.eventExt   = bus.eventValid & w_head[9];
    assign bus.fifoCount  = r_count;
    assign bus.overflow   = r_overflow;
endmodule
